pps_pulse_meas: RTL
===================

// Module: pps_pulse_meas
// PURPOSE
//  Receive-side counterpart of the PPS/pulse generator. Samples an asynchronous pulse input in the clk_125m domain and measures
//  rise-to-rise period and high width in clock cycles. Checks each period against an expected value and reports lock/loss of signal.
//  Sits between the external PPS pin (or the generator's loopback) and the register file.
// PARAMETERS
//  SYNC_STAGES   2            input synchroniser depth (>=2)
//  TIMEOUT_CLKS  250000000    cycles without accepted rise before loss (2 s @125 MHz)
//  TOL_CLKS      125          allowed |period - exp_period| for a good period
//  LOCK_COUNT    3            consecutive good periods required for lock (1..15)
//  MIN_WIDTH     4            minimum high cycles for a valid pulse (glitch filter only)
// PORTS
//  clk_125m     in   1   sole clock
//  user_reset   in   1   asynchronous, active-high reset
//  pps_in       in   1   asynchronous pulse input
//  exp_period   in   32  expected period in clocks (quasi-static)
//  period_out   out  32  last measured rise-to-rise period
//  period_vld   out  1   1-cycle strobe, period_out updated
//  width_out    out  32  last measured high width
//  width_vld    out  1   1-cycle strobe, width_out updated
//  pps_lock     out  1   level, LOCKED state
//  pps_lost     out  1   level, timeout occurred, cleared by next accepted rise
//  edge_cnt     out  16  accepted rises, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: all outputs, counters and sync flops = 0; state IDLE.
//  - pps_in -> SYNC_STAGES flops -> pps_s; pps_d = pps_s delayed 1; rise = pps_s&~pps_d, fall = ~pps_s&pps_d.
//  - per_cnt: on accepted rise <=1, else +1 saturating at 0xFFFFFFFF. Rises N cycles apart capture period N.
//  - wid_cnt: <=1 on accepted rise, +1 while pps_s high; on fall, width_out<=wid_cnt, width_vld=1 next cycle.
//    High for W cycles captures W. A fall with no prior accepted rise since reset/loss produces no width_vld.
//  - States: IDLE (no rise yet), ARMED (counting, not locked), LOCKED, LOST.
//    IDLE/LOST --rise--> ARMED: no period_vld; pps_lost<=0; good_cnt<=0.
//    ARMED/LOCKED --rise--> period_out<=per_cnt, period_vld pulses 1 cycle later. Good if |per_cnt-exp_period|<=TOL_CLKS.
//    The difference is computed in 33-bit unsigned, no wrap.
//    Good: good_cnt+1 (saturating at LOCK_COUNT); ARMED->LOCKED when good_cnt reaches LOCK_COUNT.
//    Bad: good_cnt<=0, LOCKED->ARMED.
//    ARMED/LOCKED with per_cnt==TIMEOUT_CLKS and no rise -> LOST: pps_lost<=1, good_cnt<=0.
//    IDLE never times out.
//  - pps_lock = (state==LOCKED), registered; drops the cycle after the bad/timeout decision.
//  - Simultaneous rise and timeout in the same cycle: the rise wins, no LOST.
//  - A rise and a fall cannot coincide (single sampled signal). width_vld and period_vld may assert in different cycles independently.
//  - edge_cnt increments on every accepted rise, including the IDLE/LOST->ARMED rise.
//  - Latency: pps_in edge to strobe = SYNC_STAGES+2 cycles.
//  - Asynchronous reset mid-pulse: everything cleared; a pulse already high at release gives no rise until it goes low then high.
// CONFIGURATION
//  PPS_MEAS_GLITCH_FILT_EN defined:
//    - A rise is accepted only after pps_s has stayed high MIN_WIDTH consecutive cycles; the acceptance cycle replaces the raw rise.
//    - The offset is constant, so period is unaffected.
//    - Highs shorter than MIN_WIDTH: ignored entirely (no edge_cnt, no width_vld, no state change).
//    - Width is still measured from the raw rise, so the reported W is the true width.
//  Not defined: the raw rise is accepted immediately; MIN_WIDTH is unused.
// TESTING (TIMEOUT_CLKS=1000, TOL_CLKS=2, LOCK_COUNT=3, MIN_WIDTH=4, exp_period=100)
//  1. Pulses of width 7 every 100 cycles, x5:
//     - width_out=7 on each pulse.
//     - First rise: no period_vld; then period_out=100 x4.
//     - pps_lock=1 after the 4th rise; edge_cnt=5.
//  2. Locked, then one period of 103:
//     - period_out=103, pps_lock->0.
//     - Three periods of 101 re-lock; 98 is counted as good.
//  3. Locked, pps_in held low:
//     - pps_lost=1, pps_lock=0 when per_cnt==1000.
//     - Next rise: pps_lost=0, no period_vld, state ARMED.
//  4. Rise arrives exactly at the timeout cycle -> no pps_lost, period_out=1000.
//  5. With PPS_MEAS_GLITCH_FILT_EN, a 2-cycle glitch between pulses:
//     - No edge_cnt change, no strobes.
//     - Periods stay 100; width_out=7.
//     - Without the macro: extra period_vld strobes and lock is lost.
//  6. user_reset asserted mid-pulse while LOCKED:
//     - All outputs 0 immediately.
//     - After release, the held-high input gives no rise until its next rising edge.

Source files
------------

// File: rtl/pps_pulse_meas_if.sv
// PPS measurement bus: pulse input, expected period and measurement results.
interface pps_pulse_meas_if;
    logic        pps_in;
    logic [31:0] exp_period;
    logic [31:0] period_out;
    logic        period_vld;
    logic [31:0] width_out;
    logic        width_vld;
    logic        pps_lock;
    logic        pps_lost;
    logic [15:0] edge_cnt;

    modport master (
        output pps_in, exp_period,
        input  period_out, period_vld, width_out, width_vld,
        input  pps_lock, pps_lost, edge_cnt
    );

    modport slave (
        input  pps_in, exp_period,
        output period_out, period_vld, width_out, width_vld,
        output pps_lock, pps_lost, edge_cnt
    );
endinterface

// File: rtl/pps_pulse_meas.sv
// PPS receiver: measures rise-to-rise period and high width, tracks lock/loss.
// Define PPS_MEAS_GLITCH_FILT_EN to accept rises only after MIN_WIDTH high cycles.
module pps_pulse_meas #(
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_CLKS = 250000000,
    parameter int TOL_CLKS     = 125,
    parameter int LOCK_COUNT   = 3,
    parameter int MIN_WIDTH    = 4
) (
    input  logic             clk_125m,
    input  logic             user_reset,
    pps_pulse_meas_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_LOCKED,
        S_LOST
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic        pps_s;
    logic        pps_d_q, pps_d_d;
    logic        seen_low_q, seen_low_d;
    logic        arm_q, arm_d;
    logic [31:0] per_cnt_q, per_cnt_d;
    logic [31:0] wid_cnt_q, wid_cnt_d;
    logic [31:0] period_q, period_d;
    logic [31:0] width_q, width_d;
    logic        per_evt_q, per_evt_d;
    logic        wid_evt_q, wid_evt_d;
    logic        period_vld_q, period_vld_d;
    logic        width_vld_q, width_vld_d;
    logic        lock_q, lock_d;
    logic        lost_q, lost_d;
    logic [15:0] edge_q, edge_d;
    logic [3:0]  good_q, good_d;
    logic [3:0]  good_inc;

    logic        raw_rise;
    logic        fall;
    logic        acc_rise;
    logic        timeout;
    logic        good;
    logic [32:0] per_ext;
    logic [32:0] exp_ext;
    logic [32:0] diff;

    assign pps_s    = sync_q[SYNC_STAGES-1];
    // A rise only counts once a genuine low has been seen after reset,
    // so a pulse already high at reset release is not taken as an edge.
    assign raw_rise = pps_s & ~pps_d_q & seen_low_q;
    assign fall     = ~pps_s & pps_d_q;

`ifdef PPS_MEAS_GLITCH_FILT_EN
    localparam int HW = $clog2(MIN_WIDTH + 1);

    logic [HW-1:0] hi_q, hi_d;

    always_comb begin
        hi_d = '0;
        if (pps_s && seen_low_q)
            hi_d = (hi_q == HW'(MIN_WIDTH)) ? hi_q : hi_q + 1'b1;
    end

    assign acc_rise = pps_s & seen_low_q & (hi_q == HW'(MIN_WIDTH - 1));

    always_ff @(posedge clk_125m or posedge user_reset) begin
        if (user_reset) hi_q <= '0;
        else            hi_q <= hi_d;
    end
`else
    localparam int unused_min_width = MIN_WIDTH;

    assign acc_rise = raw_rise;
`endif

    assign per_ext  = {1'b0, per_cnt_q};
    assign exp_ext  = {1'b0, bus.exp_period};
    assign diff     = (per_ext >= exp_ext) ? per_ext - exp_ext
                                           : exp_ext - per_ext;
    assign good     = diff <= 33'(TOL_CLKS);
    assign timeout  = per_cnt_q == 32'(TIMEOUT_CLKS);
    assign good_inc = (good_q >= 4'(LOCK_COUNT)) ? good_q : good_q + 4'd1;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], bus.pps_in};
        fill_d     = {fill_q[SYNC_STAGES-2:0], 1'b1};
        pps_d_d    = pps_s;
        seen_low_d = seen_low_q | (fill_q[SYNC_STAGES-1] & ~pps_s);

        state_d   = state_q;
        good_d    = good_q;
        lost_d    = lost_q;
        period_d  = period_q;
        per_evt_d = 1'b0;
        edge_d    = acc_rise ? edge_q + 16'd1 : edge_q;

        if (acc_rise)
            per_cnt_d = 32'd1;
        else
            per_cnt_d = (&per_cnt_q) ? per_cnt_q : per_cnt_q + 32'd1;

        // Width restarts on the raw edge so filtering never shortens it.
        if (raw_rise)
            wid_cnt_d = 32'd1;
        else if (pps_s && !(&wid_cnt_q))
            wid_cnt_d = wid_cnt_q + 32'd1;
        else
            wid_cnt_d = wid_cnt_q;

        unique case (state_q)
            S_IDLE, S_LOST: begin
                if (acc_rise) begin
                    state_d = S_ARMED;
                    lost_d  = 1'b0;
                    good_d  = 4'd0;
                end
            end
            default: begin
                if (acc_rise) begin
                    period_d  = per_cnt_q;
                    per_evt_d = 1'b1;
                    if (good) begin
                        good_d = good_inc;
                        if (good_inc == 4'(LOCK_COUNT))
                            state_d = S_LOCKED;
                    end else begin
                        good_d  = 4'd0;
                        state_d = S_ARMED;
                    end
                end else if (timeout) begin
                    state_d = S_LOST;
                    lost_d  = 1'b1;
                    good_d  = 4'd0;
                end
            end
        endcase

        if (acc_rise)
            arm_d = 1'b1;
        else if (raw_rise || state_d == S_LOST)
            arm_d = 1'b0;
        else
            arm_d = arm_q;

        wid_evt_d    = fall & arm_q;
        width_d      = wid_evt_d ? wid_cnt_q : width_q;
        period_vld_d = per_evt_q;
        width_vld_d  = wid_evt_q;
        lock_d       = state_d == S_LOCKED;
    end

    always_ff @(posedge clk_125m or posedge user_reset) begin
        if (user_reset) begin
            state_q      <= S_IDLE;
            sync_q       <= '0;
            fill_q       <= '0;
            pps_d_q      <= 1'b0;
            seen_low_q   <= 1'b0;
            arm_q        <= 1'b0;
            per_cnt_q    <= '0;
            wid_cnt_q    <= '0;
            period_q     <= '0;
            width_q      <= '0;
            per_evt_q    <= 1'b0;
            wid_evt_q    <= 1'b0;
            period_vld_q <= 1'b0;
            width_vld_q  <= 1'b0;
            lock_q       <= 1'b0;
            lost_q       <= 1'b0;
            edge_q       <= '0;
            good_q       <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            fill_q       <= fill_d;
            pps_d_q      <= pps_d_d;
            seen_low_q   <= seen_low_d;
            arm_q        <= arm_d;
            per_cnt_q    <= per_cnt_d;
            wid_cnt_q    <= wid_cnt_d;
            period_q     <= period_d;
            width_q      <= width_d;
            per_evt_q    <= per_evt_d;
            wid_evt_q    <= wid_evt_d;
            period_vld_q <= period_vld_d;
            width_vld_q  <= width_vld_d;
            lock_q       <= lock_d;
            lost_q       <= lost_d;
            edge_q       <= edge_d;
            good_q       <= good_d;
        end
    end

    assign bus.period_out = period_q;
    assign bus.period_vld = period_vld_q;
    assign bus.width_out  = width_q;
    assign bus.width_vld  = width_vld_q;
    assign bus.pps_lock   = lock_q;
    assign bus.pps_lost   = lost_q;
    assign bus.edge_cnt   = edge_q;

endmodule
